// File: rtl/sha256_wrap_pkg.sv
// Register map, control/status bit positions and FSM encoding shared by the
// SHA-256 Avalon wrapper and its bench.
package sha256_wrap_pkg;

   localparam int unsigned REG_CTRL   = 0;
   localparam int unsigned REG_STATUS = 1;
   localparam int unsigned REG_DATA   = 2;
   localparam int unsigned REG_HASH0  = 8;
   localparam int          HASH_WORDS = 8;

   localparam int CTRL_START   = 0;
   localparam int CTRL_NEW_MSG = 1;
   localparam int CTRL_CLR     = 2;

   localparam int STAT_BUSY      = 0;
   localparam int STAT_DONE      = 1;
   localparam int STAT_FULL      = 2;
   localparam int STAT_EMPTY     = 3;
   localparam int STAT_OVF       = 4;
   localparam int STAT_ERR       = 5;
   localparam int STAT_COUNT_LSB = 8;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PULSE = 2'd1,
      S_RUN   = 2'd2
   } wrap_state_e;

endpackage

// File: rtl/sha256_word_fifo.sv
// First-word-fall-through word FIFO holding one SHA-256 message block.
// Head word is presented combinationally and reads as zero while empty.
module sha256_word_fifo #(
   parameter  int DATA_W = 32,
   parameter  int DEPTH  = 16,
   localparam int PTR_W  = $clog2(DEPTH),
   localparam int CNT_W  = PTR_W + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic [CNT_W-1:0]  count,
   output logic              full,
   output logic              empty
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_reg;
   logic [PTR_W-1:0]  rd_ptr_reg;
   logic [CNT_W-1:0]  count_reg;
   logic [CNT_W-1:0]  count_next;
   logic              do_push;
   logic              do_pop;

   assign full    = (count_reg == CNT_W'(DEPTH));
   assign empty   = (count_reg == '0);
   assign count   = count_reg;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = empty ? '0 : mem[rd_ptr_reg];

   always_comb begin
      count_next = count_reg;
      case ({do_push, do_pop})
         2'b10:   count_next = count_reg + CNT_W'(1);
         2'b01:   count_next = count_reg - CNT_W'(1);
         default: count_next = count_reg;
      endcase
   end

   // Storage carries no reset; the pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_reg] <= din;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         count_reg <= count_next;
      end
   end

endmodule

// File: rtl/sha256_avalon_wrapper.sv
// Avalon-MM slave feeding message words to the SHA-256 controller, issuing the
// start pulse and capturing the final hash when the core reports done.
module sha256_avalon_wrapper
   import sha256_wrap_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 16,
   parameter int ADDR_W     = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [ADDR_W-1:0]          avs_address,
   input  logic                       avs_write,
   input  logic [DATA_W-1:0]          avs_writedata,
   input  logic                       avs_read,
   output logic [DATA_W-1:0]          avs_readdata,
   output logic                       start,
   output logic                       resetn_new_input,
   input  logic                       wrapper_data_request,
   output logic [DATA_W-1:0]          wrapper_data,
   output logic                       wrapper_data_valid,
   input  logic                       done,
   input  logic [HASH_WORDS*DATA_W-1:0] hash_in
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   wrap_state_e       state_reg, state_next;
   logic              new_msg_reg;
   logic              done_d_reg;
   logic              done_flag_reg, done_flag_next;
   logic              ovf_reg, ovf_next;
   logic              err_reg, err_next;
   logic [DATA_W-1:0] readdata_reg;
   logic [DATA_W-1:0] read_mux;
   logic [DATA_W-1:0] status_word;
   logic [DATA_W-1:0] hash_word [HASH_WORDS];

   logic              fifo_full, fifo_empty, fifo_push;
   logic [CNT_W-1:0]  fifo_count;

   logic wr_ctrl, wr_data, ctrl_start, ctrl_clr;
   logic start_ok, start_rej, ovf_set, done_rise, capture, busy;

   assign wr_ctrl    = avs_write && (avs_address == ADDR_W'(REG_CTRL));
   assign wr_data    = avs_write && (avs_address == ADDR_W'(REG_DATA));
   assign ctrl_start = wr_ctrl && avs_writedata[CTRL_START];
   assign ctrl_clr   = wr_ctrl && avs_writedata[CTRL_CLR];
   assign start_ok   = ctrl_start && (state_reg == S_IDLE) && fifo_full;
   assign start_rej  = ctrl_start && !start_ok;
   assign fifo_push  = wr_data && !fifo_full;
   assign ovf_set    = wr_data && fifo_full;
   assign done_rise  = done && !done_d_reg;
   assign capture    = (state_reg == S_RUN) && done_rise;
   assign busy       = (state_reg != S_IDLE);

   assign wrapper_data_valid = wrapper_data_request && !fifo_empty;
   assign avs_readdata       = readdata_reg;

   sha256_word_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .pop   (wrapper_data_valid),
      .din   (avs_writedata),
      .dout  (wrapper_data),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (reset) state_reg <= S_IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:  if (start_ok) state_next = S_PULSE;
         S_PULSE: state_next = S_RUN;
         S_RUN:   if (done_rise) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      start            = (state_reg == S_PULSE);
      resetn_new_input = !((state_reg == S_PULSE) && new_msg_reg);
   end

   // Clear is applied before the set events so CLR+START in one write behaves.
   always_comb begin
      done_flag_next = done_flag_reg;
      ovf_next       = ovf_reg;
      err_next       = err_reg;
      if (ctrl_clr) begin
         done_flag_next = 1'b0;
         ovf_next       = 1'b0;
         err_next       = 1'b0;
      end
      if (start_ok)  done_flag_next = 1'b0;
      if (capture)   done_flag_next = 1'b1;
      if (ovf_set)   ovf_next       = 1'b1;
      if (start_rej) err_next       = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         new_msg_reg   <= 1'b0;
         done_d_reg    <= 1'b0;
         done_flag_reg <= 1'b0;
         ovf_reg       <= 1'b0;
         err_reg       <= 1'b0;
      end else begin
         if (start_ok) new_msg_reg <= avs_writedata[CTRL_NEW_MSG];
         done_d_reg    <= done;
         done_flag_reg <= done_flag_next;
         ovf_reg       <= ovf_next;
         err_reg       <= err_next;
      end
   end

   // H0 sits in the most significant word of hash_in.
   genvar gi;
   generate
      for (gi = 0; gi < HASH_WORDS; gi++) begin : g_hash
         logic [DATA_W-1:0] word_reg;
         always_ff @(posedge clk) begin
            if (reset)        word_reg <= '0;
            else if (capture) word_reg <= hash_in[(HASH_WORDS-gi)*DATA_W-1 -: DATA_W];
         end
         assign hash_word[gi] = word_reg;
      end
   endgenerate

   always_comb begin
      status_word                               = '0;
      status_word[STAT_BUSY]                    = busy;
      status_word[STAT_DONE]                    = done_flag_reg;
      status_word[STAT_FULL]                    = fifo_full;
      status_word[STAT_EMPTY]                   = fifo_empty;
      status_word[STAT_OVF]                     = ovf_reg;
      status_word[STAT_ERR]                     = err_reg;
      status_word[STAT_COUNT_LSB +: CNT_W]      = fifo_count;
      read_mux = '0;
      if (avs_address == ADDR_W'(REG_STATUS))
         read_mux = status_word;
      else if (avs_address >= ADDR_W'(REG_HASH0))
         read_mux = hash_word[3'(avs_address - ADDR_W'(REG_HASH0))];
   end

   always_ff @(posedge clk) begin
      if (reset)         readdata_reg <= '0;
      else if (avs_read) readdata_reg <= read_mux;
   end

endmodule
